shift_add_mult_ctrl: RTL and testbench

- Sequential shift-add multiplier stage that consumes two unsigned operands and produces their product over WIDTH iterations.
- Holds the operands in loadable registers and drives their load/clear enables from an internal FSM.
- Sits downstream of the operand-capture registers; feeds the product display/output register.
- Default configuration is the team's 4x4 multiplier: 8-bit product, start/done handshake.

---
 rtl/shift_add_mult_ctrl_pkg.sv | 18 +
 rtl/shift_add_mult_ctrl_if.sv | 16 +
 rtl/shift_add_mult_ctrl_iter_counter.sv | 32 +++
 rtl/shift_add_mult_ctrl.sv | 105 ++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared constants for the shift-add multiplier: state encoding, default width,
// and the iteration-counter width helper.
package shift_add_mult_ctrl_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // A 1-bit operand still needs a 1-bit counter.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Start/done handshake plus operand and product buses of the shift-add multiplier.
interface shift_add_mult_ctrl_if
   import shift_add_mult_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (output start, a, b, input busy, done, product);
   modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_mult_ctrl_iter_counter.sv
// Iteration counter: cleared when an operation is accepted, counts CALC cycles,
// flags the last iteration.
module mult_iter_counter
   import shift_add_mult_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic clk,
   input  logic clr,
   input  logic clear,
   input  logic inc,
   output logic tc
);
   localparam int CW = cnt_width(WIDTH);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (inc)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tc = (cnt_q == CW'(WIDTH - 1));
endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-add multiplier: one add/shift iteration per clock, WIDTH
// iterations per product, start/done handshake with a one-cycle done pulse.
module shift_add_mult_ctrl
   import shift_add_mult_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                 clk,
   input  logic                 clr,
   shift_add_mult_ctrl_if.slave bus
);
   localparam int PW = 2 * WIDTH;

   state_e             state_q, state_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH:0]     acc_q, acc_d;
   logic [PW-1:0]      product_q, product_d;

   logic               accept, inc, tc;
   logic [WIDTH:0]     sum;
   logic [PW:0]        shifted;

   mult_iter_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .clr   (clr),
      .clear (accept),
      .inc   (inc),
      .tc    (tc)
   );

   // acc is one bit wider than the operand so the adder carry survives the shift.
   always_comb begin
      sum     = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      shifted = {sum, mplier_q} >> 1;

      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      product_d = product_q;
      accept    = 1'b0;
      inc       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (bus.start) begin
               accept   = 1'b1;
               mcand_d  = bus.a;
               mplier_d = bus.b;
               acc_d    = '0;
               busy_d   = 1'b1;
               state_d  = ST_CALC;
            end
         end
         ST_CALC: begin
            inc      = 1'b1;
            acc_d    = shifted[PW:WIDTH];
            mplier_d = shifted[WIDTH-1:0];
            if (tc) begin
               product_d = shifted[PW-1:0];
               done_d    = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         product_q <= product_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl (WIDTH=4) with hand-computed products.
module tb_shift_add_mult_ctrl;
   logic clk = 1'b0;
   logic clr = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   shift_add_mult_ctrl_if #(.WIDTH(4)) bus ();

   shift_add_mult_ctrl #(.WIDTH(4)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete operation from IDLE with a single-cycle start pulse.
   task automatic do_run(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
      bus.a = a; bus.b = b; bus.start = 1'b1;
      tick();
      chk("run_busy_e0", 16'(bus.busy), 16'd1);
      chk("run_done_e0", 16'(bus.done), 16'd0);
      bus.start = 1'b0;
      bus.a = ~a; bus.b = ~b;
      for (int i = 1; i < 4; i++) begin
         tick();
         chk("run_done_early", 16'(bus.done), 16'd0);
      end
      tick();
      chk("run_done_e4", 16'(bus.done), 16'd1);
      chk("run_busy_e4", 16'(bus.busy), 16'd1);
      chk("run_prod_e4", 16'(bus.product), 16'(exp));
      tick();
      chk("run_done_e5", 16'(bus.done), 16'd0);
      chk("run_busy_e5", 16'(bus.busy), 16'd0);
      chk("run_prod_hold", 16'(bus.product), 16'(exp));
   endtask

   initial begin
      int t1, t2, ndone;
      bus.start = 1'b0; bus.a = '0; bus.b = '0;

      // reset
      repeat (3) tick();
      chk("rst_busy", 16'(bus.busy), 16'd0);
      chk("rst_done", 16'(bus.done), 16'd0);
      chk("rst_prod", 16'(bus.product), 16'h00);
      clr = 1'b0;
      tick();
      chk("idle_busy", 16'(bus.busy), 16'd0);

      do_run(4'd3,  4'd5, 8'h0F);
      do_run(4'd15, 4'd15, 8'hE1);
      do_run(4'd0,  4'd9, 8'h00);
      do_run(4'd9,  4'd1, 8'h09);

      // asynchronous clear between edges
      #2 clr = 1'b1;
      #1 chk("async_clr_prod", 16'(bus.product), 16'h00);
      chk("async_clr_busy", 16'(bus.busy), 16'd0);
      #1 clr = 1'b0;
      tick();

      // operands and start changing during a run
      bus.a = 4'd2; bus.b = 4'd7; bus.start = 1'b1;
      tick();
      bus.start = 1'b0; bus.a = 4'd15; bus.b = 4'd15;
      ndone = 0;
      tick();
      ndone += int'(bus.done);
      bus.start = 1'b1;
      tick();
      ndone += int'(bus.done);
      bus.start = 1'b0;
      tick();
      ndone += int'(bus.done);
      tick();
      ndone += int'(bus.done);
      chk("ign_done_e4", 16'(bus.done), 16'd1);
      bus.start = 1'b1;
      tick();
      ndone += int'(bus.done);
      bus.start = 1'b0;
      chk("ign_busy_e5", 16'(bus.busy), 16'd0);
      chk("ign_prod", 16'(bus.product), 16'h0E);
      tick();
      ndone += int'(bus.done);
      chk("ign_no_rerun", 16'(bus.busy), 16'd0);
      chk("ign_one_done", 16'(ndone), 16'd1);

      // start held high: back-to-back runs
      bus.a = 4'd4; bus.b = 4'd4; bus.start = 1'b1;
      t1 = -1; t2 = -1;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (bus.done) begin
            if (t1 < 0) t1 = k;
            else if (t2 < 0) t2 = k;
         end
      end
      bus.start = 1'b0;
      chk("b2b_first", 16'(t1), 16'd4);
      chk("b2b_gap", 16'(t2 - t1), 16'd6);
      chk("b2b_prod", 16'(bus.product), 16'h10);
      repeat (8) tick();

      // abort mid-operation
      bus.a = 4'd6; bus.b = 4'd7; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      #3 clr = 1'b1;
      #1 chk("abort_prod", 16'(bus.product), 16'h00);
      chk("abort_busy", 16'(bus.busy), 16'd0);
      #1 clr = 1'b0;
      ndone = 0;
      repeat (6) begin
         tick();
         ndone += int'(bus.done);
      end
      chk("abort_no_done", 16'(ndone), 16'd0);
      chk("abort_prod_hold", 16'(bus.product), 16'h00);
      do_run(4'd6, 4'd7, 8'h2A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
